// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential shift-and-add multiplier.
package mult_pkg;

  localparam int unsigned DEFAULT_N = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/nbit_adder_carry.sv
// W-bit unsigned adder exposing the carry-out as a separate bit.
module nbit_adder_carry #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  always_comb begin
    {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};
  end

endmodule

// File: rtl/nbit_seq_multiplier.sv
// Unsigned N x N shift-and-add multiplier: one adder reused over N cycles,
// start/done handshake, 2N-bit product held until the next completion.
module nbit_seq_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   in0,
  input  logic [N-1:0]   in1,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] out0
);

  localparam int unsigned CW = $clog2(N);

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [N-1:0]    acc_q, acc_d;
  logic [N-1:0]    mcand_q, mcand_d;
  logic [N-1:0]    mplier_q, mplier_d;
  logic [2*N-1:0]  out_q, out_d;
  logic            done_q, done_d;

  logic [N-1:0]    addend;
  logic [N-1:0]    sum;
  logic            carry;
  logic [N-1:0]    acc_shift;
  logic [N-1:0]    mplier_shift;
  logic            last_iter;

  assign addend = mplier_q[0] ? mcand_q : '0;

  nbit_adder_carry #(
    .W (N)
  ) u_adder (
    .a_i    (acc_q),
    .b_i    (addend),
    .sum_o  (sum),
    .cout_o (carry)
  );

  // {carry, sum, mplier} shifted right by one: the carry lands in the top of
  // acc, and the sum LSB becomes the new product bit entering mplier.
  assign acc_shift    = {carry, sum[N-1:1]};
  assign mplier_shift = {sum[0], mplier_q[N-1:1]};
  assign last_iter    = (count_q == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      out_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      out_q    <= out_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    out_d    = out_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = in0;
          mplier_d = in1;
          acc_d    = '0;
          count_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = acc_shift;
        mplier_d = mplier_shift;
        count_d  = count_q + CW'(1);
        if (last_iter) begin
          out_d   = {acc_shift, mplier_shift};
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign out0 = out_q;

endmodule

// File: tb/tb_nbit_seq_multiplier.sv
// Directed-vector bench for nbit_seq_multiplier at N=16.
module tb_nbit_seq_multiplier;

  localparam int unsigned N = 16;

  logic           clk;
  logic           rst;
  logic           start;
  logic [N-1:0]   in0;
  logic [N-1:0]   in1;
  logic           busy;
  logic           done;
  logic [2*N-1:0] out0;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  nbit_seq_multiplier #(
    .N (N)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in0   (in0),
    .in1   (in1),
    .busy  (busy),
    .done  (done),
    .out0  (out0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a one-cycle start; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    in0   = a;
    in1   = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges until done is seen (bounded); cyc == limit means timeout.
  task automatic wait_done(input int limit, output int cyc, output int busy_cnt,
                           output logic busy_at_done);
    cyc      = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && cyc < limit) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    busy_at_done = busy;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    in0   = '0;
    in1   = '0;
    #3;
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
    else pass_cnt++;
    chk_cnt++;
    if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done);
    else pass_cnt++;
    chk_cnt++;
    if (out0 !== 32'h0) $display("FAIL reset_out0 got %h want 00000000", out0);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
    else pass_cnt++;
  endtask

  task automatic test_small();
    int cyc, bcnt;
    logic bdone;
    start_op(16'd3, 16'd5);
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL small_busy_start got %b want 1", busy);
    else pass_cnt++;
    wait_done(40, cyc, bcnt, bdone);
    chk_cnt++;
    if (cyc !== 16) $display("FAIL small_latency got %0d want 16", cyc);
    else pass_cnt++;
    chk_cnt++;
    if (bcnt !== 16) $display("FAIL small_busy_cycles got %0d want 16", bcnt);
    else pass_cnt++;
    chk_cnt++;
    if (bdone !== 1'b0) $display("FAIL small_busy_at_done got %b want 0", bdone);
    else pass_cnt++;
    chk_cnt++;
    if (out0 !== 32'h0000000F) $display("FAIL small_out0 got %h want 0000000f", out0);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (done !== 1'b0 || out0 !== 32'h0000000F)
      $display("FAIL small_done_pulse got done=%b out0=%h want 0 0000000f", done, out0);
    else pass_cnt++;
  endtask

  task automatic test_max();
    int cyc, bcnt;
    logic bdone;
    start_op(16'hFFFF, 16'hFFFF);
    wait_done(40, cyc, bcnt, bdone);
    chk_cnt++;
    if (cyc !== 16) $display("FAIL max_latency got %0d want 16", cyc);
    else pass_cnt++;
    chk_cnt++;
    if (out0 !== 32'hFFFE0001) $display("FAIL max_out0 got %h want fffe0001", out0);
    else pass_cnt++;
  endtask

  task automatic test_zero();
    int cyc, bcnt;
    logic bdone;
    start_op(16'h0000, 16'h1234);
    wait_done(40, cyc, bcnt, bdone);
    chk_cnt++;
    if (cyc !== 16 || out0 !== 32'h0)
      $display("FAIL zero_out0 got %h after %0d want 00000000 after 16", out0, cyc);
    else pass_cnt++;
    start_op(16'h8000, 16'h0002);
    wait_done(40, cyc, bcnt, bdone);
    chk_cnt++;
    if (cyc !== 16 || out0 !== 32'h00010000)
      $display("FAIL msb_out0 got %h after %0d want 00010000 after 16", out0, cyc);
    else pass_cnt++;
  endtask

  task automatic test_ignore_start();
    int cyc, bcnt, ndone;
    logic bdone;
    start_op(16'd7, 16'd9);
    @(negedge clk);
    in0   = 16'd1;
    in1   = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in0   = 16'hAAAA;
    in1   = 16'h5555;
    wait_done(40, cyc, bcnt, bdone);
    chk_cnt++;
    if (cyc !== 14) $display("FAIL ignore_latency got %0d want 14", cyc);
    else pass_cnt++;
    chk_cnt++;
    if (out0 !== 32'd63) $display("FAIL ignore_out0 got %0d want 63", out0);
    else pass_cnt++;
    ndone = 0;
    repeat (25) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    chk_cnt++;
    if (ndone !== 0) $display("FAIL ignore_no_second_op got %0d active cycles want 0", ndone);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int cyc, bcnt, ndone;
    logic bdone;
    start_op(16'd100, 16'd200);
    repeat (8) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if (out0 !== 32'h0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL abort_outputs got out0=%h busy=%b done=%b want 0 0 0", out0, busy, done);
    else pass_cnt++;
    @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk_cnt++;
    if (ndone !== 0 || out0 !== 32'h0)
      $display("FAIL abort_no_done got %0d dones out0=%h want 0 00000000", ndone, out0);
    else pass_cnt++;
    start_op(16'd2, 16'd3);
    wait_done(40, cyc, bcnt, bdone);
    chk_cnt++;
    if (cyc !== 16 || out0 !== 32'd6)
      $display("FAIL post_abort got %0d after %0d want 6 after 16", out0, cyc);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int cyc, bcnt, cyc2;
    logic bdone;
    @(negedge clk);
    in0   = 16'd10;
    in1   = 16'd11;
    start = 1'b1;
    @(negedge clk);
    wait_done(40, cyc, bcnt, bdone);
    chk_cnt++;
    if (cyc !== 16 || out0 !== 32'd110)
      $display("FAIL b2b_first got %0d after %0d want 110 after 16", out0, cyc);
    else pass_cnt++;
    in0  = 16'd12;
    in1  = 16'd13;
    cyc2 = 0;
    do begin
      @(negedge clk);
      cyc2++;
      if (cyc2 == 1) start = 1'b0;
    end while (done !== 1'b1 && cyc2 < 40);
    chk_cnt++;
    if (cyc2 !== 17) $display("FAIL b2b_spacing got %0d want 17", cyc2);
    else pass_cnt++;
    chk_cnt++;
    if (out0 !== 32'd156) $display("FAIL b2b_second got %0d want 156", out0);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_small();
    test_max();
    test_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
